// File: rtl/ysyx_23060180_pkg.sv
// Shared constants and types for the ysyx_23060180 core and its memory models.
package ysyx_23060180_pkg;

  // Core reset pc; also the byte address of word 0 of the fetch memory.
  localparam logic [31:0] RESET_PC        = 32'h80000000;
  // ebreak encoding, returned for bad fetches so a runaway core traps.
  localparam logic [31:0] INSTR_EBREAK    = 32'h00100073;
  // Deepest read pipeline the fetch memory model supports.
  localparam int          MAX_MEM_LATENCY = 4;

  // One fetch response as it travels down the latency pipeline.
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  // True when addr is word aligned and inside [base, base + span_bytes).
  // The offset check is only trusted once addr >= base, so no wrap past 2^32.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span_bytes);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ({1'b0, off} < span_bytes) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_23060180_resp_pipe.sv
// Valid/data delay line of DEPTH register stages with async active-low clear.
// DEPTH=0 degenerates to a wire so the caller sees same-cycle data.
module ysyx_23060180_resp_pipe #(
  parameter int W     = 33,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst_n;
      assign o_valid  = i_valid;
      assign o_data   = i_data;
    end else begin : g_regs
      logic [DEPTH-1:0] r_valid;
      logic [W-1:0]     r_data [DEPTH];

      // Shift one stage per cycle; clear drops every in-flight entry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= '0;
          for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
        end else begin
          r_valid[0] <= i_valid;
          r_data[0]  <= i_data;
          for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
          end
        end
      end

      assign o_valid = r_valid[DEPTH-1];
      assign o_data  = r_data[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ysyx_23060180_imem_responder.sv
// Fetch-path memory model: answers mem_rd/mem_raddr from a word array with a
// programmable latency, plus a side-band preload port. The array is never
// reset so a loaded image survives core resets.
//
// Handshake: mem_rd is a one-cycle request with no backpressure; every cycle
// it is high out of reset is one accepted request. mem_rvalid is a strobe that
// qualifies mem_rdata and mem_err; both read as 0 while mem_rvalid is low.
module ysyx_23060180_imem_responder
  import ysyx_23060180_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_PC,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 0,
  parameter logic [31:0] ERR_DATA    = INSTR_EBREAK
) (
  input  logic        clk,
  input  logic        rstn_in,
  input  logic        mem_rd,
  input  logic [31:0] mem_raddr,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] rd_count
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

  if (LATENCY < 0 || LATENCY > MAX_MEM_LATENCY) begin : g_bad_latency
    $error("LATENCY out of range 0..%0d", MAX_MEM_LATENCY);
  end

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_rd_count;

  logic             w_rd_ok;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_ld_ok;
  logic [IDX_W-1:0] w_ld_idx;
  resp_t            w_req;
  logic             w_pipe_valid;
  resp_t            w_pipe_data;
  logic             w_out_valid;

  assign w_rd_ok  = addr_in_range(mem_raddr, BASE_ADDR, SPAN);
  assign w_rd_idx = IDX_W'((mem_raddr - BASE_ADDR) >> 2);
  assign w_ld_ok  = addr_in_range(ld_addr, BASE_ADDR, SPAN);
  assign w_ld_idx = IDX_W'((ld_addr - BASE_ADDR) >> 2);

  // Response is captured in the request cycle, before any same-edge preload
  // write lands, so a colliding read always returns the old word.
  always_comb begin
    w_req      = '0;
    w_req.err  = !w_rd_ok;
    w_req.data = w_rd_ok ? r_mem[w_rd_idx] : ERR_DATA;
  end

  ysyx_23060180_resp_pipe #(
    .W     ($bits(resp_t)),
    .DEPTH (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rstn_in),
    .i_valid (mem_rd),
    .i_data  (w_req),
    .o_valid (w_pipe_valid),
    .o_data  (w_pipe_data)
  );

  // Gating with rstn_in matters only at LATENCY=0, where the pipe is a wire.
  assign w_out_valid = w_pipe_valid & rstn_in;
  assign mem_rvalid  = w_out_valid;
  assign mem_err     = w_out_valid & w_pipe_data.err;
  assign mem_rdata   = w_out_valid ? w_pipe_data.data : '0;
  assign rd_count    = r_rd_count;

  // Preload writes; dropped while in reset or when the address is bad.
  always_ff @(posedge clk) begin
    if (rstn_in && ld_en && w_ld_ok) r_mem[w_ld_idx] <= ld_data;
  end

  // Count accepted reads; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in)    r_rd_count <= '0;
    else if (mem_rd) r_rd_count <= r_rd_count + 32'd1;
  end

endmodule
